// File: rtl/onehot_strobe_decoder.sv
// Buffered, timed one-hot decoder: queued {code, hold} requests each drive line
// (1 << code) for max(hold,1) cycles, replayed back-to-back with no idle gap.
module onehot_strobe_decoder #(
  parameter  int IN_W   = 4,
  parameter  int DEPTH  = 4,
  parameter  int HOLD_W = 4,
  localparam int OUT_W  = 2**IN_W,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_code,
  input  logic [HOLD_W-1:0] in_hold,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] CNT_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0]  LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
  localparam logic [OUT_W-1:0]  OUT_ONE  = {{(OUT_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  logic [IN_W-1:0]   code_mem [DEPTH];
  logic [HOLD_W-1:0] hold_mem [DEPTH];

  logic              empty, full, push, pop;
  logic [IN_W-1:0]   head_code;
  logic [HOLD_W-1:0] head_hold;

  assign empty     = (level_q == '0);
  assign full      = (level_q == FULL_LVL);
  assign in_ready  = !full && !flush;
  assign push      = in_valid && in_ready;
  // A pop happens when idle, or on the last cycle of the current strobe.
  assign pop       = !flush && !empty && ((state_q == IDLE) || (cnt_q == CNT_ONE));
  assign head_code = code_mem[rd_ptr_q];
  assign head_hold = hold_mem[rd_ptr_q];

  assign out       = out_q;
  assign out_valid = |out_q;
  assign level     = level_q;

  always_ff @(posedge clk) begin
    if (push) begin
      code_mem[wr_ptr_q] <= in_code;
      hold_mem[wr_ptr_q] <= in_hold;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      out_d    = '0;
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        out_d    = OUT_ONE << head_code;
        cnt_d    = (head_hold == '0) ? CNT_ONE : head_hold;
        state_d  = ACTIVE;
      end else if (state_q == ACTIVE) begin
        if (cnt_q == CNT_ONE) begin
          out_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      out_q    <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule
